// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised integer register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 4;
  localparam int unsigned RF_NRP    = 2;
  localparam int unsigned RF_PC_IDX = 15;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for late writebacks, handshake generation and
// the sticky protocol-error flag.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned PC_IDX = RF_PC_IDX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ready,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  output logic                   wb_ready,
  output logic                   wb_fire,
  output logic [(2**ADDR_W)-1:0] busy_vec,
  output logic                   hazard_err
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             haz_q, haz_d;
  logic             rsv_fire;

  always_comb begin
    rsv_ready = !busy_q[rsv_addr] && (rsv_addr != PcAddr) && !reset;
    // PC writebacks are always accepted so the error can be flagged and dropped.
    wb_ready  = (wb_addr == PcAddr) || !(we && (wa == wb_addr));
    rsv_fire  = rsv_valid && rsv_ready;
    wb_fire   = wb_valid && wb_ready;

    busy_d = busy_q;
    if (wb_fire) busy_d[wb_addr] = 1'b0;
    if (rsv_fire) busy_d[rsv_addr] = 1'b1;

    haz_d = haz_q
          | (wb_fire && !busy_q[wb_addr])
          | (wb_fire && (wb_addr == PcAddr))
          | (we && (wa != PcAddr) && busy_q[wa]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      haz_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      haz_q  <= haz_d;
    end
  end

  assign busy_vec   = busy_q;
  assign hazard_err = haz_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write bypass, a late-writeback port and a busy
// scoreboard for decode-stage stalls. Index PC_IDX reads pc_val.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NRP    = RF_NRP,
  parameter int unsigned PC_IDX = RF_PC_IDX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRP*ADDR_W-1:0]  ra,
  output logic [NRP*DATA_W-1:0]  rd,
  output logic [NRP-1:0]         rd_busy,
  input  logic [DATA_W-1:0]      pc_val,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic [DATA_W-1:0]      wd,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ready,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   wb_ready,
  output logic [(2**ADDR_W)-1:0] busy_vec,
  output logic                   hazard_err
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX);

  // The PC_IDX slot is never written, so it reduces to a constant.
  logic [DATA_W-1:0] mem_q [NREGS];
  logic              wb_fire;
  logic [ADDR_W-1:0] rd_addr;

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .PC_IDX (PC_IDX)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .wa         (wa),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rsv_ready  (rsv_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_ready   (wb_ready),
    .wb_fire    (wb_fire),
    .busy_vec   (busy_vec),
    .hazard_err (hazard_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      if (we && (wa != PcAddr)) mem_q[wa] <= wd;
      if (wb_fire && (wb_addr != PcAddr)) mem_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    rd_addr = '0;
    for (int i = 0; i < NRP; i++) begin
      rd_addr = ra[i*ADDR_W +: ADDR_W];
      if (rd_addr == PcAddr) begin
        rd[i*DATA_W +: DATA_W] = pc_val;
      end else if (we && (wa == rd_addr)) begin
        rd[i*DATA_W +: DATA_W] = wd;
      end else if (wb_fire && (wb_addr == rd_addr)) begin
        rd[i*DATA_W +: DATA_W] = wb_data;
      end else begin
        rd[i*DATA_W +: DATA_W] = mem_q[rd_addr];
      end
      rd_busy[i] = busy_vec[rd_addr];
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file.
- Provides configurable width, depth and read-port count, plus a read-only PC index.
- Adds synchronous reset, same-cycle write-to-read bypass, and a second late-writeback port for multi-cycle results (loads, multiply).
- Includes a per-register busy scoreboard so the decode stage can stall on pending destinations.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register index width; NREGS = 2**ADDR_W.
- NRP, 2, number of read ports (1..4).
- PC_IDX, 15, index that reads pc_val and is never written.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ra  in  NRP*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd  out  NRP*DATA_W  read data, combinational.
- rd_busy  out  NRP  read register i has a pending late writeback.
- pc_val  in  DATA_W  value returned for PC_IDX reads.
- we  in  1  primary (execute-stage) write enable.
- wa  in  ADDR_W  primary write address.
- wd  in  DATA_W  primary write data.
- rsv_valid  in  1  request to reserve a destination for late writeback.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ready  out  1  reservation accepted this cycle.
- wb_valid  in  1  late writeback present.
- wb_addr  in  ADDR_W  late writeback address.
- wb_data  in  DATA_W  late writeback data.
- wb_ready  out  1  late writeback accepted this cycle.
- busy_vec  out  NREGS  scoreboard state, one bit per register.
- hazard_err  out  1  sticky protocol-error flag.

Behaviour:
- Storage: NREGS-1 registers (PC_IDX excluded); writes take effect at posedge clk.
- Reset (synchronous, at posedge clk with reset=1): all registers <= 0, busy_vec <= 0, hazard_err <= 0. Reset overrides every write, reservation and writeback in the same cycle. Reset mid-reservation discards the reservation; a later wb to that register counts as an error (see below).
- Read path, per port, in priority order, all combinational:
  - ra==PC_IDX -> pc_val.
  - we && wa==ra && wa!=PC_IDX -> wd (bypass).
  - wb fire && wb_addr==ra -> wb_data (bypass).
  - otherwise -> stored value.
- rd_busy[i] = busy_vec[ra_i] as registered state. It is not cleared early by a same-cycle wb.
- Fire definitions: rsv fire = rsv_valid && rsv_ready; wb fire = wb_valid && wb_ready.
- Primary write: when we && wa!=PC_IDX, the register updates next edge. we with wa==PC_IDX is ignored silently (branching is handled elsewhere).
- Late writeback:
  - wb_ready = !(we && wa==wb_addr). The primary write wins an address collision and wb stalls one or more cycles, holding its inputs stable.
  - wb to PC_IDX: wb_ready=1, data dropped, hazard_err set.
  - On wb fire: register <= wb_data and busy[wb_addr] <= 0.
  - we and wb fire to different addresses in the same cycle: both writes land.
- Reservation:
  - rsv_ready = !busy[rsv_addr] && rsv_addr!=PC_IDX && !reset.
  - On rsv fire: busy[rsv_addr] <= 1.
  - rsv fire and wb fire to the same address in the same cycle cannot occur, because a busy bit blocks the reservation. If the register is free, the wb clears nothing and the set wins.
- hazard_err (sticky until reset) is set on:
  - wb fire to a register that is not busy;
  - wb to PC_IDX;
  - primary write to a busy register (WAW ordering violation). The write is still performed.
- Latency: read 0 cycles; write visible to stored read 1 cycle after the edge (0 cycles via bypass); busy set/clear visible 1 cycle after fire.
- All address comparisons use the full ADDR_W. There is no wrap-around; every index 0..NREGS-1 is valid.

Decomposition:
- Package regfile_pkg holds: DATA_W/ADDR_W defaults, PC_IDX, typedef reg_addr_t (logic [ADDR_W-1:0]), typedef reg_data_t.
- Sub-module rf_scoreboard: busy_vec, rsv_ready/wb_ready generation, hazard_err. Data array, read muxing and bypass stay in the top module.

Test Plan:
- Reset with we=1, wa=3, wd=0xDEAD_BEEF asserted -> next cycle ra0=3 reads 0, busy_vec=0, hazard_err=0.
- we=1, wa=5, wd=0x1234 with ra0=5 same cycle -> rd0=0x1234 combinationally. Next cycle with we=0 -> rd0=0x1234. ra1=15, pc_val=0x100 -> rd1=0x100.
- rsv_addr=7 fires -> next cycle busy_vec[7]=1, rd_busy for ra=7 is 1, second rsv to 7 gives rsv_ready=0. Then wb 7/0xAA fires -> next cycle busy[7]=0, r7=0xAA.
- we=1, wa=7 and wb_valid, wb_addr=7 same cycle -> wb_ready=0 and r7 takes wd. Following cycle wb_ready=1 and r7 takes wb_data.
- wb to unreserved r2 -> write performed, hazard_err=1 and stays 1 until reset. Separately, wb_addr=15 -> no write, hazard_err=1.
- Reserve r9, assert reset, then wb to r9 -> busy_vec=0 after reset and the wb sets hazard_err.
